wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  Parametrised register-file writeback stage for the femtoRV32 core. Selects one of NSRC result
//  sources (ALU, PC+4, branch target, load data, ...), registers it with rd/we, and stalls the
//  front end while a load waits for data memory. Sits between execute/memory and the register file.
// PARAMETERS
//  XLEN     32  datapath width
//  NSRC     4   number of writeback sources (>=2)
//  SEL_W    2   select width, $clog2(NSRC)
//  MEM_SRC  3   select index meaning "load data" (taken from mem_rdata, not in_src)
//  RA_W     5   register address width
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           reset, asynchronous, active-low
//  in_valid   in   1           instruction result presented
//  in_ready   out  1           stage can accept (=1 in IDLE only)
//  in_sel     in   SEL_W       source select
//  in_src     in   NSRC*XLEN   flattened sources, source k = in_src[k*XLEN +: XLEN]
//  in_rd      in   RA_W        destination register
//  in_we      in   1           register write enable
//  in_funct3  in   3           load type (LB/LH/LW/LBU/LHU encoding)
//  mem_rvalid in   1           load data valid
//  mem_rdata  in   XLEN        load data
//  flush      in   1           kill accepted/pending instruction
//  wb_valid   out  1           one-cycle pulse: wb_* holds a retired result
//  wb_we      out  1           register-file write strobe
//  wb_rd      out  RA_W        register-file write address
//  wb_data    out  XLEN        register-file write data
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: state IDLE, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
//  - All wb_* outputs registered; in_ready combinational from state only.
//  - FSM IDLE:
//    * in_valid & flush: dropped, no writeback, stay IDLE.
//    * in_valid & in_sel!=MEM_SRC: capture source, wb_valid=1 next cycle (latency 1).
//    * in_valid & in_sel==MEM_SRC & mem_rvalid: capture mem_rdata, latency 1.
//    * in_valid & in_sel==MEM_SRC & !mem_rvalid: latch rd/we/funct3, -> WAIT_MEM.
//    * mem_rvalid with no load pending: ignored.
//  - FSM WAIT_MEM: in_ready=0, in_* ignored.
//    * flush (priority over mem_rvalid): -> IDLE, no writeback.
//    * mem_rvalid: capture mem_rdata, wb_valid=1 next cycle, -> IDLE.
//  - Back-to-back non-load results accepted every cycle; one wb_valid pulse per accepted result.
//  - in_sel >= NSRC selects source 0.
//  - wb_we = captured we & wb_valid & (wb_rd != 0); x0 never written.
//  - wb_data/wb_rd hold last captured value when wb_valid=0.
//  - Reset mid-WAIT_MEM: returns to IDLE, pending load discarded.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined: load data formatted per latched funct3 using mem_rdata[1:0]-aligned
//   low bits: 000 LB sign-ext byte, 001 LH sign-ext half, 010 LW word, 100 LBU, 101 LHU zero-ext;
//   other codes pass word. Data taken from low byte/half (aligner upstream).
//  Not defined: mem_rdata written unmodified; in_funct3 ignored.
// TESTING
//  1 reset: rst_n=0 mid-cycle -> all wb_* =0 immediately, in_ready=1 after release.
//  2 sel=1, in_src[1]=0x0000_0104, rd=5, we=1 -> next cycle wb_valid=1, wb_we=1, rd=5, data=0x104.
//  3 sel=MEM_SRC, mem_rvalid low 3 cycles then 1 with 0xDEAD_BEEF -> in_ready=0 three cycles,
//    wb_data=0xDEAD_BEEF one cycle after rvalid.
//  4 rd=0, we=1, sel=0 -> wb_valid=1, wb_we=0.
//  5 load pending, flush and mem_rvalid same cycle -> no wb_valid, back to IDLE.
//  6 WB_LOAD_EXT_EN, funct3=000, mem_rdata=0x0000_0080 -> wb_data=0xFFFF_FF80; funct3=100 -> 0x80.

Source files
------------

// File: rtl/wb_select_stage.sv
// Writeback stage: selects one of NSRC result sources, registers it with rd/we, and
// holds the front end while a load waits for data memory. Optional macro: WB_LOAD_EXT_EN.
module wb_select_stage #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 4,
  parameter int SEL_W   = 2,
  parameter int MEM_SRC = 3,
  parameter int RA_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [NSRC*XLEN-1:0] in_src,
  input  logic [RA_W-1:0]      in_rd,
  input  logic                 in_we,
  input  logic [2:0]           in_funct3,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 flush,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [RA_W-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_data
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t          state_r;
  logic [RA_W-1:0] pend_rd_r;
  logic            pend_we_r;
  logic [2:0]      pend_funct3_r;
  logic [XLEN-1:0] src_data_s;
  logic            is_load_s;
  logic            rd_nonzero_s;
  logic            pend_rd_nonzero_s;

  // Load data formatting; with extension disabled the word passes through untouched.
  function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
`ifdef WB_LOAD_EXT_EN
    case (f3)
      3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b010:  r = d;
      3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
`else
    r = d;
`endif
    return r;
  endfunction

`ifndef WB_LOAD_EXT_EN
  logic unused_funct3_s;
  assign unused_funct3_s = ^{in_funct3, pend_funct3_r};
`endif

  // Source mux; out-of-range selects fall back to source 0.
  always_comb begin
    src_data_s = in_src[XLEN-1:0];
    for (int k = 1; k < NSRC; k++) begin
      src_data_s = (int'(in_sel) == k) ? in_src[k*XLEN +: XLEN] : src_data_s;
    end
  end

  // Decode helpers derived from the current inputs and the pending load.
  always_comb begin
    is_load_s         = (int'(in_sel) == MEM_SRC);
    rd_nonzero_s      = (in_rd != {RA_W{1'b0}});
    pend_rd_nonzero_s = (pend_rd_r != {RA_W{1'b0}});
    in_ready          = (state_r == IDLE);
  end

  // Control FSM with registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pend_rd_r     <= {RA_W{1'b0}};
      pend_we_r     <= 1'b0;
      pend_funct3_r <= 3'b000;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= {RA_W{1'b0}};
      wb_data       <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && !flush) begin
            if (!is_load_s) begin
              wb_valid <= 1'b1;
              wb_we    <= in_we && rd_nonzero_s;
              wb_rd    <= in_rd;
              wb_data  <= src_data_s;
            end else if (mem_rvalid) begin
              wb_valid <= 1'b1;
              wb_we    <= in_we && rd_nonzero_s;
              wb_rd    <= in_rd;
              wb_data  <= format_load(in_funct3, mem_rdata);
            end else begin
              wb_valid      <= 1'b0;
              wb_we         <= 1'b0;
              pend_rd_r     <= in_rd;
              pend_we_r     <= in_we;
              pend_funct3_r <= in_funct3;
              state_r       <= WAIT_MEM;
            end
          end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        WAIT_MEM: begin
          // Flush wins over data arriving in the same cycle.
          if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            state_r  <= IDLE;
          end else if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= pend_we_r && pend_rd_nonzero_s;
            wb_rd    <= pend_rd_r;
            wb_data  <= format_load(pend_funct3_r, mem_rdata);
            state_r  <= IDLE;
          end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: expected writebacks are queued at drive time and
// compared when the stage retires them one cycle later.
module tb_wb_select_stage;
  localparam int XLEN = 32, NSRC = 4, SEL_W = 2, MEM_SRC = 3, RA_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0, in_ready, in_we = 1'b0, flush = 1'b0, mem_rvalid = 1'b0;
  logic [SEL_W-1:0]     in_sel = '0;
  logic [XLEN-1:0]      src [NSRC];
  logic [NSRC*XLEN-1:0] in_src;
  logic [RA_W-1:0]      in_rd = '0;
  logic [2:0]           in_funct3 = 3'b010;
  logic [XLEN-1:0]      mem_rdata = '0;
  logic                 wb_valid, wb_we;
  logic [RA_W-1:0]      wb_rd;
  logic [XLEN-1:0]      wb_data;

  assign in_src = {src[3], src[2], src[1], src[0]};

  wb_select_stage #(.XLEN(XLEN), .NSRC(NSRC), .SEL_W(SEL_W), .MEM_SRC(MEM_SRC), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_src(in_src), .in_rd(in_rd), .in_we(in_we), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data));

  always #5 clk = ~clk;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t             exp_q[$];
  int              n_checks = 0;
  int              n_pass = 0;
  logic            m_wait = 1'b0;
  logic [RA_W-1:0] m_rd = '0;
  logic            m_we = 1'b0;
  logic [2:0]      m_f3 = 3'b000;
  int              stall_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] exp_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
`ifdef WB_LOAD_EXT_EN
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
`else
    return d;
`endif
  endfunction

  // Model the accepted transaction for the current inputs, clock once, then compare.
  task automatic tick();
    wb_t e;
    check("in_ready", {63'd0, in_ready}, {63'd0, !m_wait});
    if (!m_wait) begin
      if (in_valid && !flush) begin
        if (in_sel != MEM_SRC[SEL_W-1:0])
          exp_q.push_back({in_we && (in_rd != 0), in_rd, src[in_sel]});
        else if (mem_rvalid)
          exp_q.push_back({in_we && (in_rd != 0), in_rd, exp_load(in_funct3, mem_rdata)});
        else begin
          m_wait = 1'b1; m_rd = in_rd; m_we = in_we; m_f3 = in_funct3;
        end
      end
    end else if (flush) begin
      m_wait = 1'b0;
    end else if (mem_rvalid) begin
      exp_q.push_back({m_we && (m_rd != 0), m_rd, exp_load(m_f3, mem_rdata)});
      m_wait = 1'b0;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wb_valid", {63'd0, wb_valid}, 64'd1);
      check("wb_we", {63'd0, wb_we}, {63'd0, e.we});
      check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
      check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
    end else begin
      check("wb_valid_idle", {63'd0, wb_valid}, 64'd0);
      check("wb_we_idle", {63'd0, wb_we}, 64'd0);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_we"}, {63'd0, wb_we}, 64'd0);
    check({tag, "_rd"}, {59'd0, wb_rd}, 64'd0);
    check({tag, "_data"}, {32'd0, wb_data}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) src[i] = 32'h1000 * (i + 1);
    #12;
    check_wb_zero("rst_init");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // sel=1 non-load result, latency 1
    src[1] = 32'h0000_0104; in_sel = 2'd1; in_rd = 5'd5; in_we = 1'b1; in_valid = 1'b1;
    tick();
    check("t2_data", {32'd0, wb_data}, 64'h104);
    idle_inputs(); tick();

    // load waits three cycles for data
    in_sel = MEM_SRC[SEL_W-1:0]; in_rd = 5'd7; in_we = 1'b1; in_funct3 = 3'b010; in_valid = 1'b1;
    tick();
    in_sel = 2'd0; in_rd = 5'd9;
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (!in_ready) stall_cnt++;
      mem_rvalid = (i == 2); mem_rdata = 32'hDEAD_BEEF;
      tick();
    end
    check("t3_stall_cycles", 64'(stall_cnt), 64'd3);
    check("t3_data", {32'd0, wb_data}, 64'hDEAD_BEEF);
    idle_inputs(); tick();

    // x0 destination suppresses the write strobe
    in_sel = 2'd0; in_rd = 5'd0; in_we = 1'b1; in_valid = 1'b1;
    tick();
    check("t4_we", {63'd0, wb_we}, 64'd0);

    // flush and data in the same cycle while a load is pending
    in_sel = MEM_SRC[SEL_W-1:0]; in_rd = 5'd3; in_valid = 1'b1; mem_rvalid = 1'b0;
    tick();
    in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    check("t5_ready", {63'd0, in_ready}, 64'd1);
    tick();

    // stray data with nothing pending, and a flushed non-load
    mem_rvalid = 1'b1; tick();
    idle_inputs(); in_valid = 1'b1; flush = 1'b1; in_sel = 2'd2; in_rd = 5'd4; tick();
    idle_inputs(); tick();

`ifdef WB_LOAD_EXT_EN
    in_sel = MEM_SRC[SEL_W-1:0]; in_rd = 5'd6; in_we = 1'b1; in_valid = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080; in_funct3 = 3'b000;
    tick();
    check("t6_lb", {32'd0, wb_data}, 64'hFFFF_FF80);
    in_funct3 = 3'b100;
    tick();
    check("t6_lbu", {32'd0, wb_data}, 64'h0000_0080);
    idle_inputs(); tick();
`endif

    // back-to-back non-load results
    for (int i = 0; i < 4; i++) begin
      in_sel = SEL_W'(i % MEM_SRC); in_rd = RA_W'(i + 10); in_we = 1'b1; in_valid = 1'b1;
      src[i % MEM_SRC] = $urandom;
      tick();
    end
    idle_inputs(); tick();

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = SEL_W'($urandom_range(0, NSRC - 1));
      in_rd      = RA_W'($urandom);
      in_we      = 1'($urandom);
      in_funct3  = 3'($urandom);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      flush      = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs(); tick();

    // asynchronous reset while a load is pending
    in_sel = 2'd1; in_rd = 5'd8; in_we = 1'b1; in_valid = 1'b1; src[1] = 32'hCAFE_0001;
    tick();
    in_sel = MEM_SRC[SEL_W-1:0]; mem_rvalid = 1'b0;
    tick();
    idle_inputs();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_wb_zero("rst_mid");
    m_wait = 1'b0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    check("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    idle_inputs(); tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
